// File: rtl/pcm_tdm_scheduler.sv
// pcm_tdm_scheduler
// Collects one 8-bit PCM sample per channel per frame through valid/ready
// handshakes. Serializes a fixed TDM frame MSB first: a sync word, then one
// slot per channel. A channel with no fresh sample gets the idle word and an
// underrun pulse.
module pcm_tdm_scheduler #(
   parameter int         NCH       = 4,
   parameter logic [7:0] SYNC_WORD = 8'h9B,
   parameter logic [7:0] IDLE_WORD = 8'hD5
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             enable,
   input  logic [NCH*8-1:0] ch_data,
   input  logic [NCH-1:0]   ch_valid,
   output logic [NCH-1:0]   ch_ready,
   output logic             out_pcm,
   output logic             out_valid,
   output logic             frame_start,
   output logic [2:0]       slot,
   output logic [2:0]       bit_idx,
   output logic [NCH-1:0]   underrun,
   output logic [7:0]       underrun_cnt
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_SYNC,
      ST_CHAN
   } state_e;

   localparam logic [2:0] LAST_SLOT = 3'(NCH);

   // The sequencer (state, seq_slot, seq_bit) names the bit that the next
   // clock edge will put on the line. The output registers then describe the
   // bit currently on the line, so a slot word is loaded on the very edge
   // that emits its MSB.
   state_e         state_q, state_d;
   logic [2:0]     seq_slot_q, seq_slot_d;
   logic [2:0]     seq_bit_q, seq_bit_d;

   // sr_q[7] is the bit currently on the line.
   logic [7:0]     sr_q, sr_d;
   logic           out_valid_q, out_valid_d;
   logic           frame_start_q, frame_start_d;
   logic [2:0]     slot_q, slot_d;
   logic [2:0]     bit_idx_q, bit_idx_d;
   logic [NCH-1:0] underrun_q, underrun_d;
   logic [7:0]     underrun_cnt_q, underrun_cnt_d;

   // Per-channel one-sample holding registers.
   logic [NCH-1:0] full_q, full_d;
   logic [7:0]     buf_q [NCH];
   logic [7:0]     buf_d [NCH];

   logic [7:0]     load_word;

   // A channel is ready whenever its buffer is empty and reset is not held.
   assign ch_ready     = ~full_q & {NCH{~reset}};
   assign out_pcm      = sr_q[7];
   assign out_valid    = out_valid_q;
   assign frame_start  = frame_start_q;
   assign slot         = slot_q;
   assign bit_idx      = bit_idx_q;
   assign underrun     = underrun_q;
   assign underrun_cnt = underrun_cnt_q;

   // Next-state logic: frame sequencing, slot loads, underruns and handshakes.
   always_comb begin
      // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
      state_d        = state_q;
      seq_slot_d     = seq_slot_q;
      seq_bit_d      = seq_bit_q;
      sr_d           = sr_q;
      out_valid_d    = 1'b0;
      frame_start_d  = 1'b0;
      slot_d         = '0;
      bit_idx_d      = '0;
      underrun_d     = '0;
      underrun_cnt_d = underrun_cnt_q;
      full_d         = full_q;
      buf_d          = buf_q;
      load_word      = IDLE_WORD;

      unique case (state_q)
         ST_IDLE: begin
            sr_d = '0;
            if (enable) begin
               state_d    = ST_SYNC;
               seq_slot_d = '0;
               seq_bit_d  = '0;
            end
         end

         ST_SYNC, ST_CHAN: begin
            out_valid_d   = 1'b1;
            slot_d        = seq_slot_q;
            bit_idx_d     = seq_bit_q;
            frame_start_d = (state_q == ST_SYNC) && (seq_bit_q == 3'd0);

            if (seq_bit_q == 3'd0) begin
               // Slot load: only a sample buffered before this edge counts.
               if (state_q == ST_SYNC) begin
                  load_word = SYNC_WORD;
               end else begin
                  for (int i = 0; i < NCH; i++) begin
                     if (seq_slot_q == 3'(i + 1)) begin
                        if (full_q[i]) begin
                           load_word = buf_q[i];
                           full_d[i] = 1'b0;
                        end else begin
                           load_word     = IDLE_WORD;
                           underrun_d[i] = 1'b1;
                           if (underrun_cnt_q != 8'hFF) begin
                              underrun_cnt_d = underrun_cnt_q + 8'd1;
                           end
                        end
                     end
                  end
               end
               sr_d = load_word;
            end else begin
               sr_d = {sr_q[6:0], 1'b0};
            end

            if (seq_bit_q != 3'd7) begin
               seq_bit_d = seq_bit_q + 3'd1;
            end else begin
               seq_bit_d = '0;
               if (state_q == ST_SYNC) begin
                  state_d    = ST_CHAN;
                  seq_slot_d = 3'd1;
               end else if (seq_slot_q != LAST_SLOT) begin
                  seq_slot_d = seq_slot_q + 3'd1;
               end else if (enable) begin
                  // Last bit of the frame: enable decides back-to-back or stop.
                  state_d    = ST_SYNC;
                  seq_slot_d = '0;
               end else begin
                  state_d    = ST_IDLE;
                  seq_slot_d = '0;
               end
            end
         end

         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Accepts cannot collide with a data load: ready implies the buffer is empty.
      for (int i = 0; i < NCH; i++) begin
         if (ch_valid[i] && ch_ready[i]) begin
            full_d[i] = 1'b1;
            buf_d[i]  = ch_data[8*i +: 8];
         end
      end
   end

   // Sequencer, shift register, output registers and full flags.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop updates from pre-edge values.
      if (reset) begin
         state_q        <= ST_IDLE;
         seq_slot_q     <= '0;
         seq_bit_q      <= '0;
         sr_q           <= '0;
         out_valid_q    <= 1'b0;
         frame_start_q  <= 1'b0;
         slot_q         <= '0;
         bit_idx_q      <= '0;
         underrun_q     <= '0;
         underrun_cnt_q <= '0;
         full_q         <= '0;
      end else begin
         state_q        <= state_d;
         seq_slot_q     <= seq_slot_d;
         seq_bit_q      <= seq_bit_d;
         sr_q           <= sr_d;
         out_valid_q    <= out_valid_d;
         frame_start_q  <= frame_start_d;
         slot_q         <= slot_d;
         bit_idx_q      <= bit_idx_d;
         underrun_q     <= underrun_d;
         underrun_cnt_q <= underrun_cnt_d;
         full_q         <= full_d;
      end
   end

   // Sample storage.
   always_ff @(posedge clk) begin
      // NOTE: sample buffers are deliberately not reset; full_q alone says whether buf_q holds a valid sample.
      buf_q <= buf_d;
   end

endmodule

// File: tb/tb_pcm_tdm_scheduler.sv
// Self-checking bench for pcm_tdm_scheduler: directed scenarios plus a
// randomized phase, every cycle compared against a frame-position model.
module tb_pcm_tdm_scheduler;

   localparam int         NCH        = 4;
   localparam int         FRAME_BITS = (NCH + 1) * 8;
   localparam logic [7:0] SYNC_WORD  = 8'h9B;
   localparam logic [7:0] IDLE_WORD  = 8'hD5;

   logic             clk = 1'b0;
   logic             reset;
   logic             enable;
   logic [NCH*8-1:0] ch_data;
   logic [NCH-1:0]   ch_valid;
   logic [NCH-1:0]   ch_ready;
   logic             out_pcm;
   logic             out_valid;
   logic             frame_start;
   logic [2:0]       slot;
   logic [2:0]       bit_idx;
   logic [NCH-1:0]   underrun;
   logic [7:0]       underrun_cnt;

   pcm_tdm_scheduler #(
      .NCH       (NCH),
      .SYNC_WORD (SYNC_WORD),
      .IDLE_WORD (IDLE_WORD)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .ch_data      (ch_data),
      .ch_valid     (ch_valid),
      .ch_ready     (ch_ready),
      .out_pcm      (out_pcm),
      .out_valid    (out_valid),
      .frame_start  (frame_start),
      .slot         (slot),
      .bit_idx      (bit_idx),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_err = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
      end
   endtask

   // ---------------- reference model ----------------
   // Frame position p runs 0..FRAME_BITS-1; slot = p/8, bit = p%8.
   bit             m_full [NCH];
   logic [7:0]     m_buf  [NCH];
   bit             m_acc  [NCH];
   int             m_next = -1;     // position the next edge emits, -1 when idle
   int             m_last_pos = -1; // position emitted at the latest edge
   logic [7:0]     m_word = '0;
   int             m_cnt = 0;
   bit             e_valid, e_pcm, e_fs, e_after_reset;
   int             e_slot, e_bit;
   logic [NCH-1:0] e_under;

   task automatic model_edge();
      bit pre_full [NCH];
      int p, s, b;
      for (int i = 0; i < NCH; i++) m_acc[i] = 1'b0;
      e_under       = '0;
      e_valid       = 1'b0;
      e_fs          = 1'b0;
      e_after_reset = 1'b0;
      m_last_pos    = -1;
      if (reset) begin
         for (int i = 0; i < NCH; i++) m_full[i] = 1'b0;
         m_next        = -1;
         m_cnt         = 0;
         e_pcm         = 1'b0;
         e_slot        = 0;
         e_bit         = 0;
         e_after_reset = 1'b1;
         return;
      end
      pre_full = m_full;
      if (m_next < 0) begin
         if (enable) m_next = 0;
      end else begin
         p = m_next;
         s = p / 8;
         b = p % 8;
         if (b == 0) begin
            if (s == 0) begin
               m_word = SYNC_WORD;
            end else if (pre_full[s-1]) begin
               m_word      = m_buf[s-1];
               m_full[s-1] = 1'b0;
            end else begin
               m_word       = IDLE_WORD;
               e_under[s-1] = 1'b1;
               if (m_cnt < 255) m_cnt++;
            end
         end
         e_valid    = 1'b1;
         e_pcm      = m_word[7-b];
         e_fs       = (p == 0);
         e_slot     = s;
         e_bit      = b;
         m_last_pos = p;
         if (p == FRAME_BITS - 1) m_next = enable ? 0 : -1;
         else                     m_next = p + 1;
      end
      for (int i = 0; i < NCH; i++) begin
         if (ch_valid[i] && !pre_full[i]) begin
            m_full[i] = 1'b1;
            m_buf[i]  = ch_data[8*i +: 8];
            m_acc[i]  = 1'b1;
         end
      end
   endtask

   task automatic compare();
      logic [NCH-1:0] exp_ready;
      for (int i = 0; i < NCH; i++) exp_ready[i] = !reset && !m_full[i];
      check("out_valid", out_valid, e_valid);
      check("frame_start", frame_start, e_fs);
      check("underrun", underrun, e_under);
      check("underrun_cnt", underrun_cnt, 64'(m_cnt));
      check("ch_ready", ch_ready, exp_ready);
      if (e_valid || e_after_reset) begin
         check("out_pcm", out_pcm, e_pcm);
         check("slot", slot, 64'(e_slot));
         check("bit_idx", bit_idx, 64'(e_bit));
      end
   endtask

   // ---------------- channel sources ----------------
   logic [7:0] src_q [NCH][$];
   int         src_rate = 100;

   task automatic drive_sources();
      for (int i = 0; i < NCH; i++) begin
         if (src_q[i].size() == 0) begin
            ch_valid[i] = 1'b0;
         end else begin
            if (!ch_valid[i] || m_acc[i]) ch_valid[i] = ($urandom_range(99) < src_rate);
            ch_data[8*i +: 8] = src_q[i][0];
         end
      end
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      #1;
      compare();
      for (int i = 0; i < NCH; i++) begin
         if (m_acc[i]) void'(src_q[i].pop_front());
      end
      drive_sources();
   endtask

   task automatic wait_pos(input int pos);
      for (int k = 0; k < 200; k++) begin
         if (m_last_pos == pos) break;
         step();
      end
      check("wait_pos", {slot, bit_idx}, 64'(pos));
   endtask

   task automatic wait_idle();
      for (int k = 0; k < 200; k++) begin
         if (m_next < 0 && !e_valid) break;
         step();
      end
      check("wait_idle", out_valid, 1'b0);
   endtask

   task automatic preload(input logic [7:0] a, input logic [7:0] b,
                          input logic [7:0] c, input logic [7:0] d, input logic [3:0] mask);
      if (mask[0]) src_q[0].push_back(a);
      if (mask[1]) src_q[1].push_back(b);
      if (mask[2]) src_q[2].push_back(c);
      if (mask[3]) src_q[3].push_back(d);
      drive_sources();
      repeat (2) step();
   endtask

   task automatic one_frame(input string tag, input logic [39:0] exp_bits);
      logic [39:0] cap;
      int          ncap;
      int          nfs;
      cap  = '0;
      ncap = 0;
      nfs  = 0;
      enable = 1'b1;
      step();
      enable = 1'b0;
      for (int k = 0; k < 45; k++) begin
         step();
         if (out_valid) begin
            cap = {cap[38:0], out_pcm};
            ncap++;
         end
         if (frame_start) nfs++;
      end
      check({tag, "_bits"}, cap, exp_bits);
      check({tag, "_len"}, 64'(ncap), 64'd40);
      check({tag, "_fs_count"}, 64'(nfs), 64'd1);
   endtask

   initial begin
      logic [7:0] slot2_bytes [$];
      logic [7:0] cur;
      int         nv;

      reset    = 1'b1;
      enable   = 1'b0;
      ch_valid = '0;
      ch_data  = '0;
      cur      = '0;
      for (int i = 0; i < NCH; i++) begin
         m_full[i] = 1'b0;
         m_buf[i]  = '0;
         m_acc[i]  = 1'b0;
      end

      // Reset state.
      repeat (2) step();
      reset = 1'b0;
      step();

      // Full frame with all channels loaded.
      preload(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'b1111);
      one_frame("t1", 40'h9BA1B2C3D4);

      // Channel 2 starved.
      preload(8'hA1, 8'hB2, 8'hC3, 8'hD4, 4'b1011);
      one_frame("t2", 40'h9BA1B2D5D4);
      check("t2_underrun_cnt", underrun_cnt, 64'd1);

      // Channel 1 offers 11 then 22 with enable held: back-to-back frames.
      src_q[1].push_back(8'h11);
      src_q[1].push_back(8'h22);
      drive_sources();
      step();
      enable = 1'b1;
      for (int k = 0; k < 2 * FRAME_BITS + 2; k++) begin
         step();
         if (out_valid && slot == 3'd2) begin
            cur = {cur[6:0], out_pcm};
            if (bit_idx == 3'd7) slot2_bytes.push_back(cur);
         end
      end
      enable = 1'b0;
      wait_idle();
      check("t3_nbytes", 64'(slot2_bytes.size()), 64'd2);
      if (slot2_bytes.size() >= 2) begin
         check("t3_frame1_slot2", slot2_bytes[0], 8'h11);
         check("t3_frame2_slot2", slot2_bytes[1], 8'h22);
      end

      // Enable dropped at bit 17: the frame still completes.
      enable = 1'b1;
      step();
      nv = 0;
      for (int k = 0; k < 60; k++) begin
         step();
         if (out_valid) nv++;
         if (m_last_pos == 16) enable = 1'b0;
      end
      check("t4_len", 64'(nv), 64'd40);
      repeat (10) step();

      // Reset at slot 2 bit 4, then restart.
      preload(8'h5A, 8'h6B, 8'h7C, 8'h8D, 4'b1111);
      enable = 1'b1;
      wait_pos(2 * 8 + 4);
      reset  = 1'b1;
      enable = 1'b0;
      step();
      reset = 1'b0;
      step();
      check("t5_ready_after_reset", ch_ready, 4'hF);
      one_frame("t5", 40'h9BD5D5D5D5);

      // Starvation for 80 frames: counter saturates, pulses continue.
      reset = 1'b1;
      step();
      reset  = 1'b0;
      enable = 1'b1;
      repeat (80 * FRAME_BITS) step();
      enable = 1'b0;
      wait_idle();
      check("t6_cnt_saturated", underrun_cnt, 64'd255);

      // Randomized traffic, enable toggling and occasional resets.
      reset = 1'b1;
      step();
      reset    = 1'b0;
      src_rate = 40;
      for (int k = 0; k < 3000; k++) begin
         for (int i = 0; i < NCH; i++) begin
            if (src_q[i].size() < 2 && $urandom_range(99) < 15) src_q[i].push_back(8'($urandom));
         end
         if ($urandom_range(99) < 3) enable = ~enable;
         reset = ($urandom_range(999) < 3);
         drive_sources();
         step();
      end
      reset  = 1'b0;
      enable = 1'b0;
      wait_idle();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/pcm_tdm_scheduler.md
# pcm_tdm_scheduler

Frame scheduler for the PCM transmit path. It collects 8-bit PCM samples from up to seven channels through valid/ready handshakes and builds a fixed TDM frame: one sync word followed by one slot per channel. Each slot is serialized MSB first, one bit per clock. It sits between the per-channel encoders and the line driver, and takes over the sequencing role of the single-channel 8-to-1 serializer.

## Interface
- NCH, 4, number of channels; legal range 1..7.
- SYNC_WORD, 8'h9B, frame alignment word sent in slot 0.
- IDLE_WORD, 8'hD5, word sent in a channel slot that has no fresh sample.

- clk  input  1  rising-edge clock; one serial bit per cycle.
- reset  input  1  synchronous, active-high.
- enable  input  1  request to transmit frames; sampled at frame boundaries only.
- ch_data  input  NCH*8  channel i sample on bits [8i+7:8i].
- ch_valid  input  NCH  channel i sample offered.
- ch_ready  output  NCH  channel i buffer empty; ch_ready[i] = ~full[i] & ~reset (combinational).
- out_pcm  output  1  serial bit, registered.
- out_valid  output  1  out_pcm carries a frame bit, registered.
- frame_start  output  1  high with bit 7 of SYNC_WORD, registered.
- slot  output  3  0 = sync slot, 1..NCH = channel slot+1, registered.
- bit_idx  output  3  bit position within slot; 0 = MSB, registered.
- underrun  output  NCH  one-cycle pulse when channel i's slot is filled with IDLE_WORD.
- underrun_cnt  output  8  total underruns, saturating at 255.

## Operation
- Per-channel holding register buf[i] with flag full[i].
  - Accept on ch_valid[i] & ch_ready[i]: buf[i] <= sample, full[i] <= 1.
  - Handshakes while reset is high are ignored.
- Shift register sr[7:0]; out_pcm = sr[7] at each bit.
- State machine states:
  - IDLE: out_valid = 0.
  - SYNC: sr loaded with SYNC_WORD.
  - CHAN: slot counter 1..NCH.
  - bit_cnt 0..7 inside SYNC and CHAN.
- Transitions:
  - IDLE -> SYNC on the edge where enable = 1.
  - SYNC bit 7 -> CHAN slot 1.
  - CHAN slot k bit 7 -> slot k+1.
  - CHAN slot NCH bit 7 -> SYNC if enable = 1, else IDLE.
- enable is sampled only in IDLE and at the last bit of slot NCH. A deassertion mid-frame lets the frame complete.
- Slot load for channel i happens at the edge that emits bit 0 of slot i+1:
  - If full[i] was 1 before that edge: sr <= buf[i] and full[i] <= 0.
  - Otherwise: sr <= IDLE_WORD, underrun[i] pulses, underrun_cnt increments (holds at 255).
- A sample accepted on the same edge as its slot load is not used for that slot. It stays buffered for the next frame, and the underrun is still reported.
- ch_ready[i] rises the cycle after a slot load empties buf[i].
- Reset (synchronous, can arrive mid-frame): the edge it is sampled aborts the frame. Resulting register values:
  - State = IDLE.
  - All full flags = 0.
  - sr = 0, out_pcm = 0, out_valid = 0, frame_start = 0, slot = 0, bit_idx = 0.
  - underrun = 0, underrun_cnt = 0.
  - ch_ready reads 0 while reset is high and all ones the cycle after.

## Timing
- Latency: enable sampled high in IDLE at edge N -> out_valid = 1, frame_start = 1, out_pcm = SYNC_WORD[7], slot = 0, bit_idx = 0 after edge N+1.
- Frame length is exactly (NCH+1)*8 cycles. Back-to-back frames have no gap cycle.
- out_valid stays continuously high for the whole frame. It falls the cycle after the last bit of slot NCH when enable = 0.
- frame_start is high for exactly one cycle per frame.
- The underrun pulse coincides with bit 0 of the starved slot.
- One channel can accept at most one sample per frame; there is no deeper buffering.

## Test plan
- Reset, preload channels 0..3 with A1, B2, C3, D4, then enable for one frame -> 40 bits 9B A1 B2 C3 D4 MSB first, starting one cycle after enable. frame_start is high only on the first bit. out_valid falls after bit 40.
- Same setup with channel 2 never loaded -> slot 3 carries D5, underrun[2] pulses once at slot 3 bit 0, underrun_cnt = 1, other slots are unaffected.
- Channel 1 holds ch_valid with 11 then 22, enable held -> ch_ready[1] is low until the slot 2 load edge and high the cycle after. Frame 1 carries 11 in slot 2, frame 2 carries 22, frames are back to back with no gap.
- Drop enable at bit 17 of a frame -> all 40 bits still emitted, then out_valid = 0 and the block stays idle until enable returns.
- Assert reset for one cycle at slot 2 bit 4 -> next cycle all outputs are 0 and buffers are empty. Re-enabling restarts with the sync word and frame_start.
- Enable with all channels starved for 80 frames (320 underruns) -> underrun_cnt reaches 255 and holds, and underrun pulses continue each slot.
